// File: rtl/ili9341_spi_responder_pkg.sv
// Shared types for the ILI9341 display-link responder: register codes,
// pixel colour format and decoder state encoding.
package ili9341_spi_responder_pkg;

    // Command opcodes recognised by the decoder (other values pass through last_command)
    typedef enum logic [7:0] {
        NOP     = 8'h00,
        SWRESET = 8'h01,
        CASET   = 8'h2A,
        PASET   = 8'h2B,
        RAMWR   = 8'h2C
    } ILI9341_register_t;

    // RGB565 pixel, high byte arrives first on the wire
    typedef logic [15:0] ILI9341_color_t;

    // Decoder states
    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_PARAM = 2'd1,
        S_RAMWR = 2'd2
    } decoder_state_t;

endpackage

// File: rtl/ili9341_spi_responder_spi_byte_receiver.sv
// Mode-0 SPI byte receiver: synchronises the raw SPI pins into the clk
// domain, detects sclk rising edges and assembles MSB-first bytes.
module spi_byte_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       data_commandb,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   sclk_prev;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;

    logic csb_s;
    logic sclk_s;
    logic mosi_s;
    logic dc_s;
    logic sclk_rise;

    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    // Equal-depth synchronizer chains keep mosi/dc aligned with the sclk edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_sync  <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], data_commandb};
            sclk_prev <= sclk_s;
        end
    end

    // Shift bits in while selected; deselect drops any partial byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (csb_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_s};
                    byte_dc    <= dc_s;
                    bit_cnt    <= 3'd0;
                end else begin
                    shift   <= {shift[5:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ili9341_spi_responder.sv
// ILI9341 panel-side model: decodes SWRESET/CASET/PASET/RAMWR and turns
// RAMWR payload into per-pixel strobes following the panel's window wrap.
module ili9341_spi_responder
    import ili9341_spi_responder_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              spi_csb,
    input  logic                              spi_clk,
    input  logic                              spi_mosi,
    output logic                              spi_miso,
    input  logic                              data_commandb,
    output logic                              pixel_valid,
    output logic [$clog2(DISPLAY_WIDTH)-1:0]  pixel_x,
    output logic [$clog2(DISPLAY_HEIGHT)-1:0] pixel_y,
    output ILI9341_color_t                    pixel_color,
    output logic                              frame_done,
    output ILI9341_register_t                 last_command
);

    localparam int          XW         = $clog2(DISPLAY_WIDTH);
    localparam int          YW         = $clog2(DISPLAY_HEIGHT);
    localparam logic [15:0] COL_LIMIT  = 16'(DISPLAY_WIDTH);
    localparam logic [15:0] PAGE_LIMIT = 16'(DISPLAY_HEIGHT);
    localparam logic [15:0] COL_MAX    = 16'(DISPLAY_WIDTH - 1);
    localparam logic [15:0] PAGE_MAX   = 16'(DISPLAY_HEIGHT - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;

    decoder_state_t state;
    logic [1:0]     param_idx;
    logic           param_is_page;
    logic [23:0]    param_buf;
    logic [15:0]    col_start, col_end, page_start, page_end;
    logic [XW-1:0]  cur_x;
    logic [YW-1:0]  cur_y;
    logic [7:0]     hi_byte;
    logic           hi_pending;

    logic [15:0] new_start, new_end, limit;
    logic        window_ok, at_col_end, at_page_end;

    assign spi_miso    = 1'b0;
    assign new_start   = param_buf[23:8];
    assign new_end     = {param_buf[7:0], byte_data};
    assign limit       = param_is_page ? PAGE_LIMIT : COL_LIMIT;
    assign window_ok   = (new_start <= new_end) && (new_end < limit);
    assign at_col_end  = (16'(cur_x) == col_end);
    assign at_page_end = (16'(cur_y) == page_end);

    spi_byte_receiver #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk           (clk),
        .rst           (rst),
        .spi_csb       (spi_csb),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .data_commandb (data_commandb),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_dc       (byte_dc)
    );

    // Command/parameter decoder, window registers, cursor and pixel strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_CMD;
            param_idx     <= 2'd0;
            param_is_page <= 1'b0;
            param_buf     <= 24'd0;
            col_start     <= 16'd0;
            col_end       <= COL_MAX;
            page_start    <= 16'd0;
            page_end      <= PAGE_MAX;
            cur_x         <= '0;
            cur_y         <= '0;
            hi_byte       <= 8'd0;
            hi_pending    <= 1'b0;
            pixel_valid   <= 1'b0;
            pixel_x       <= '0;
            pixel_y       <= '0;
            pixel_color   <= '0;
            frame_done    <= 1'b0;
            last_command  <= NOP;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (byte_valid) begin
                if (!byte_dc) begin
                    last_command <= ILI9341_register_t'(byte_data);
                    hi_pending   <= 1'b0;
                    case (byte_data)
                        CASET, PASET: begin
                            state         <= S_PARAM;
                            param_idx     <= 2'd0;
                            param_is_page <= (byte_data == PASET);
                        end
                        RAMWR: begin
                            cur_x <= col_start[XW-1:0];
                            cur_y <= page_start[YW-1:0];
                            state <= S_RAMWR;
                        end
                        SWRESET: begin
                            col_start  <= 16'd0;
                            col_end    <= COL_MAX;
                            page_start <= 16'd0;
                            page_end   <= PAGE_MAX;
                            cur_x      <= '0;
                            cur_y      <= '0;
                            state      <= S_CMD;
                        end
                        default: state <= S_CMD;
                    endcase
                end else begin
                    case (state)
                        S_PARAM: begin
                            param_buf <= {param_buf[15:0], byte_data};
                            param_idx <= param_idx + 2'd1;
                            if (param_idx == 2'd3) begin
                                if (window_ok) begin
                                    if (param_is_page) begin
                                        page_start <= new_start;
                                        page_end   <= new_end;
                                    end else begin
                                        col_start <= new_start;
                                        col_end   <= new_end;
                                    end
                                end
                                state <= S_CMD;
                            end
                        end
                        S_RAMWR: begin
                            if (!hi_pending) begin
                                hi_byte    <= byte_data;
                                hi_pending <= 1'b1;
                            end else begin
                                hi_pending  <= 1'b0;
                                pixel_valid <= 1'b1;
                                pixel_x     <= cur_x;
                                pixel_y     <= cur_y;
                                pixel_color <= {hi_byte, byte_data};
                                frame_done  <= at_col_end && at_page_end;
                                if (at_col_end) begin
                                    cur_x <= col_start[XW-1:0];
                                    cur_y <= at_page_end ? page_start[YW-1:0] : cur_y + 1'b1;
                                end else begin
                                    cur_x <= cur_x + 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/ili9341_spi_responder.md
Name: ili9341_spi_responder

Overview:
- SPI secondary that models the ILI9341 end of the display link. Used as a display model in simulation and as a capture block on FPGA (e.g. mirroring the panel to a VGA framebuffer).
- Receives the 4-wire stream (csb, sclk, mosi, data_commandb) from our display controller.
- Decodes SWRESET/CASET/PASET/RAMWR and turns RAMWR payload into per-pixel write strobes with (x, y, RGB565) coordinates.
- Tracks the column/page window and its wrap-around exactly as the panel does.

Parameters:
- DISPLAY_WIDTH, 240, columns; x range 0..DISPLAY_WIDTH-1.
- DISPLAY_HEIGHT, 320, rows; y range 0..DISPLAY_HEIGHT-1.
- SYNC_STAGES, 2, synchronizer depth on csb/sclk/mosi/data_commandb; minimum 2.

Ports:
- clk  in  1  system clock; must be ≥4× the sclk frequency.
- rst  in  1  asynchronous, active-high reset.
- spi_csb  in  1  chip select, active low.
- spi_clk  in  1  SPI clock, mode 0.
- spi_mosi  in  1  serial data, MSB first.
- spi_miso  out  1  tied 0; reads are not supported.
- data_commandb  in  1  1 = data byte, 0 = command byte; sampled with bit 7 of each byte.
- pixel_valid  out  1  one-cycle strobe per completed pixel.
- pixel_x  out  $clog2(DISPLAY_WIDTH)  column of the pixel being strobed.
- pixel_y  out  $clog2(DISPLAY_HEIGHT)  row of the pixel being strobed.
- pixel_color  out  16 (ILI9341_color_t)  RGB565; high byte is received first.
- frame_done  out  1  strobe coincident with the pixel at (col_end, page_end).
- last_command  out  8 (ILI9341_register_t)  most recent command byte received.

Behaviour:
- Reset values:
  - pixel_valid=0, frame_done=0, spi_miso=0, last_command=NOP.
  - Window: col 0..DISPLAY_WIDTH-1, page 0..DISPLAY_HEIGHT-1.
  - Cursor at (0,0); FSM in S_CMD; byte shifter and pending high byte cleared.
- Byte receiver:
  - All inputs pass through SYNC_STAGES flops; sclk rising edge is detected on the synchronized signal.
  - On each rising edge with csb low, shift in mosi.
  - Bit counter runs 0..7. On the 8th bit, byte_valid pulses for one cycle together with byte_data and byte_dc (dc sampled at the 8th bit).
  - When csb is high, the bit counter is held at 0, so a partial byte is discarded. csb does not otherwise change decoder state.
- Decoder FSM, states S_CMD, S_PARAM, S_RAMWR:
  - Any byte with dc=0, in any state: update last_command, discard any pending high byte, then dispatch:
    - CASET 0x2A or PASET 0x2B → S_PARAM, param index 0.
    - RAMWR 0x2C → load cursor to (col_start, page_start), go to S_RAMWR.
    - SWRESET 0x01 → window and cursor return to reset values, go to S_CMD.
    - Any other command → S_CMD.
  - Data bytes received in S_CMD are ignored.
  - S_PARAM:
    - Collect 4 bytes {start_hi, start_lo, end_hi, end_lo}.
    - On the 4th byte, commit only if start ≤ end and end < the dimension limit; otherwise keep the old window. Either case returns to S_CMD.
    - Extra data bytes after the 4th are ignored.
  - S_RAMWR:
    - Each first data byte is held as the high byte. The second data byte completes the pixel.
    - On completion, the next cycle asserts pixel_valid with the current cursor and color {hi, lo}.
    - Latency: pixel_valid is high exactly 1 clk after the low byte's byte_valid.
    - Cursor advance after each pixel:
      - if x == col_end then x ← col_start and (y ← page_start if y == page_end, else y+1);
      - else x+1.
    - frame_done is asserted with the pixel strobed at (col_end, page_end). The stream continues and wraps; it does not stop.
- Simultaneity: only one byte event can occur per clk, so byte events never collide. An async reset mid-byte or mid-pixel clears everything immediately, including any strobe in flight.
- Widths: all start/end comparisons use 16 bits; the cursor is truncated to the port widths.

Decomposition:
- Add CASET, PASET and SWRESET to the ILI9341_register_t enum in ili9341_defines.sv; reuse ILI9341_color_t there.
- Sub-module spi_byte_receiver: synchronizers, edge detect, shifter, byte_valid/byte_data/byte_dc.
- Decoder FSM and cursor logic live in the top module.

Test Plan:
- Reset, then RAMWR followed by 241 pixels of 0xF800 → pixels 0..239 at y=0 with x 0..239; pixel 240 at (0,1); each pixel_valid 1 clk after its low byte.
- CASET 00 0A 00 0B, PASET 00 05 00 06, RAMWR, 5 pixels → (10,5),(11,5),(10,6),(11,6) with frame_done on the 4th; 5th at (10,5).
- CASET 00 F0 00 10 (start>end) then RAMWR, 1 pixel → window unchanged, pixel at (0,0); last_command=0x2C.
- csb raised after 5 bits, then a clean RAMWR plus 2 bytes → partial byte dropped; one pixel strobed correctly.
- In RAMWR: one data byte, then command NOP, then RAMWR plus 2 bytes → half pixel discarded; color equals the new 2 bytes; no stray strobe.
- rst asserted between high and low byte → outputs clear asynchronously; after release, data bytes produce no pixel_valid until RAMWR is received.
